// File: rtl/fx_sample_scheduler.sv
// fx_sample_scheduler: per-tick input FIFO -> effect core -> output FIFO sequencer with Avalon CSRs; SAMPLE_COUNT_EN adds a sample counter at 0x07
module fx_sample_scheduler #(
    parameter int DATA_W   = 32,
    parameter int TICK_DIV = 1042,
    parameter int CORE_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        avl_address,
    input  logic              avl_read,
    input  logic              avl_write,
    input  logic [DATA_W-1:0] avl_writedata,
    output logic [DATA_W-1:0] avl_readdata,
    input  logic              in_rdempty,
    output logic              in_rdreq,
    input  logic [DATA_W-1:0] in_q,
    input  logic              out_wrfull,
    output logic              out_wrreq,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] fx_gain,
    output logic [DATA_W-1:0] fx_boost,
    output logic              fx_bypass,
    output logic [DATA_W-1:0] fx_input,
    output logic              fx_valid,
    input  logic [DATA_W-1:0] fx_out
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, READ, LATCH, PROC, STORE} state_t;
    state_t state, next;
    logic [CW-1:0] tick_cnt;
    logic [3:0] lat_cnt;
    logic [DATA_W-1:0] gain, boost, rdata;
    logic [1:0] ctrl;
    logic [2:0] sticky, set;
    logic tick, busy, wr_status;
`ifdef SAMPLE_COUNT_EN
    logic [31:0] sample_cnt;
`endif
    assign tick = ctrl[0] && tick_cnt == CW'(TICK_DIV - 1);
    assign busy = state != IDLE;
    assign wr_status = avl_write && avl_address == 5'h03;
    // {overflow, underflow, tick_overrun} lines up with STATUS b4..b2
    assign set = {state == STORE && out_wrfull, !busy && tick && in_rdempty, busy && tick};
    assign in_rdreq = state == READ;
    assign out_wrreq = state == STORE && !out_wrfull;
    // the core result is valid during STORE, so it is forwarded alongside out_wrreq
    assign out_data = state == STORE ? fx_out : '0;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = tick && !in_rdempty ? READ : IDLE;
            READ:    next = LATCH;
            LATCH:   next = PROC;
            PROC:    next = lat_cnt == 4'd0 ? STORE : PROC;
            STORE:   next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        rdata = '0;
        case (avl_address)
            5'h01:   rdata = gain;
            5'h02:   rdata = boost;
            5'h03:   rdata = DATA_W'({sticky, 1'b0, busy});
            5'h04:   rdata = DATA_W'(ctrl);
`ifdef SAMPLE_COUNT_EN
            5'h07:   rdata = DATA_W'(sample_cnt);
`endif
            default: rdata = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            lat_cnt      <= '0;
            gain         <= '0;
            boost        <= '0;
            ctrl         <= '0;
            sticky       <= '0;
            avl_readdata <= '0;
            fx_gain      <= '0;
            fx_boost     <= '0;
            fx_bypass    <= 1'b0;
            fx_valid     <= 1'b0;
            fx_input     <= '0;
`ifdef SAMPLE_COUNT_EN
            sample_cnt   <= '0;
`endif
        end else begin
            state        <= next;
            tick_cnt     <= ctrl[0] && !tick ? tick_cnt + 1'b1 : '0;
            lat_cnt      <= state == LATCH ? 4'(CORE_LAT - 1) : state == PROC ? lat_cnt - 4'd1 : lat_cnt;
            gain         <= avl_write && avl_address == 5'h01 ? avl_writedata : gain;
            boost        <= avl_write && avl_address == 5'h02 ? avl_writedata : boost;
            ctrl         <= avl_write && avl_address == 5'h04 ? avl_writedata[1:0] : ctrl;
            sticky       <= (sticky & ~(wr_status ? avl_writedata[4:2] : 3'b0)) | set;
            avl_readdata <= avl_read ? rdata : avl_readdata;
            fx_gain      <= state == IDLE ? gain : fx_gain;
            fx_boost     <= state == IDLE ? boost : fx_boost;
            fx_bypass    <= ctrl[1];
            fx_valid     <= state == LATCH;
            fx_input     <= state == LATCH ? in_q : fx_input;
`ifdef SAMPLE_COUNT_EN
            sample_cnt   <= avl_write && avl_address == 5'h07 ? '0 : sample_cnt + 32'(out_wrreq);
`endif
        end
    end
endmodule

// File: tb/tb_fx_sample_scheduler.sv
// tb_fx_sample_scheduler: register table, scoreboarded sample path and corner sequences for fx_sample_scheduler
module tb_fx_sample_scheduler;
    localparam logic [31:0] K = 32'h0000_444C;
    logic clk = 1'b0, reset = 1'b0, avl_read = 1'b0, avl_write = 1'b0, b_sel = 1'b0;
    logic [4:0] avl_address = '0;
    logic [31:0] avl_writedata = '0;
    logic [31:0] rd_a, in_q_a, out_data_a, gain_a, boost_a, input_a, fx_out_a;
    logic in_rdempty_a = 1'b1, in_rdreq_a, out_wrfull_a = 1'b0, out_wrreq_a, bypass_a, valid_a;
    logic [31:0] rd_b, out_data_b, gain_b, boost_b, input_b, fx_out_b;
    logic in_rdreq_b, out_wrreq_b, bypass_b, valid_b;
    logic [31:0] pipe_a [4];
    logic [31:0] pipe_b [4];
    logic [31:0] in_fifo [$];
    logic [31:0] exp_q [$];
    int tests = 0, fails = 0, cyc = 0;
    int rd_cnt_a = 0, wr_cnt_a = 0, last_rd_a = 0, rd_cnt_b = 0, wr_cnt_b = 0, last_rd_b = 0;
    typedef struct {logic [4:0] addr; logic wr; logic [31:0] wd; logic [31:0] exp;} vec_t;
    vec_t vt [10];

    fx_sample_scheduler #(.DATA_W(32), .TICK_DIV(16), .CORE_LAT(4)) dut_a (
        .clk(clk), .reset(reset), .avl_address(avl_address), .avl_read(avl_read),
        .avl_write(avl_write && !b_sel), .avl_writedata(avl_writedata), .avl_readdata(rd_a),
        .in_rdempty(in_rdempty_a), .in_rdreq(in_rdreq_a), .in_q(in_q_a),
        .out_wrfull(out_wrfull_a), .out_wrreq(out_wrreq_a), .out_data(out_data_a),
        .fx_gain(gain_a), .fx_boost(boost_a), .fx_bypass(bypass_a), .fx_input(input_a),
        .fx_valid(valid_a), .fx_out(fx_out_a));
    fx_sample_scheduler #(.DATA_W(32), .TICK_DIV(4), .CORE_LAT(4)) dut_b (
        .clk(clk), .reset(reset), .avl_address(avl_address), .avl_read(avl_read),
        .avl_write(avl_write && b_sel), .avl_writedata(avl_writedata), .avl_readdata(rd_b),
        .in_rdempty(1'b0), .in_rdreq(in_rdreq_b), .in_q(32'h0000_1234),
        .out_wrfull(1'b0), .out_wrreq(out_wrreq_b), .out_data(out_data_b),
        .fx_gain(gain_b), .fx_boost(boost_b), .fx_bypass(bypass_b), .fx_input(input_b),
        .fx_valid(valid_b), .fx_out(fx_out_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // core models: result = input ^ K exactly 4 cycles after fx_valid, garbage otherwise
    always @(posedge clk) begin
        pipe_a[0] <= valid_a ? input_a ^ K : 32'hDEAD_BEEF;
        pipe_b[0] <= valid_b ? input_b ^ K : 32'hDEAD_BEEF;
        for (int i = 1; i < 4; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
        if (in_rdreq_a) in_q_a <= in_fifo.size() > 0 ? in_fifo.pop_front() : 32'hBAD0_BAD0;
    end
    assign fx_out_a = pipe_a[3];
    assign fx_out_b = pipe_b[3];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        in_rdempty_a = in_fifo.size() == 0;
        if (in_rdreq_a) begin rd_cnt_a++; last_rd_a = cyc; end
        if (out_wrreq_a) begin
            wr_cnt_a++;
            chk("a_latency", cyc - last_rd_a, 6);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_wr: got out_wrreq data %h expected no write", out_data_a);
            end else chk("a_out_data", out_data_a, exp_q.pop_front());
        end
        if (in_rdreq_b) begin
            rd_cnt_b++;
            if (rd_cnt_b > 1) chk("b_period", cyc - last_rd_b, 8);
            last_rd_b = cyc;
        end
        if (out_wrreq_b) begin
            wr_cnt_b++;
            chk("b_latency", cyc - last_rd_b, 6);
            chk("b_out_data", out_data_b, 32'h0000_5678);
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        avl_address = a; avl_writedata = d; avl_write = 1'b1;
        step;
        avl_write = 1'b0;
    endtask
    task automatic rd(input logic [4:0] a);
        avl_address = a; avl_read = 1'b1;
        step;
        avl_read = 1'b0;
    endtask
    task automatic push_in(input logic [31:0] v, input logic expect_out);
        in_fifo.push_back(v);
        if (expect_out) exp_q.push_back(v ^ K);
    endtask
    task automatic wait_rd(input string n);
        for (int i = 0; i < 60 && !in_rdreq_a; i++) step;
        chk(n, in_rdreq_a, 1'b1);
    endtask
    task automatic wait_wr(input string n);
        for (int i = 0; i < 20 && !out_wrreq_a; i++) step;
        chk(n, out_wrreq_a, 1'b1);
    endtask

    initial begin
        int r0, w0;
        vt[0] = '{5'h01, 1'b1, 32'h0000_00AA, 32'h0000_00AA};
        vt[1] = '{5'h02, 1'b1, 32'h1234_5678, 32'h1234_5678};
        vt[2] = '{5'h04, 1'b1, 32'hFFFF_FFFE, 32'h0000_0002};
        vt[3] = '{5'h03, 1'b1, 32'h0000_001F, 32'h0000_0000};
        vt[4] = '{5'h00, 1'b1, 32'h0000_FFFF, 32'h0000_0000};
        vt[5] = '{5'h05, 1'b1, 32'h0000_FFFF, 32'h0000_0000};
        vt[6] = '{5'h1F, 1'b1, 32'h0000_FFFF, 32'h0000_0000};
        vt[7] = '{5'h01, 1'b0, 32'h0000_0000, 32'h0000_00AA};
        vt[8] = '{5'h07, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vt[9] = '{5'h04, 1'b0, 32'h0000_0000, 32'h0000_0002};
        repeat (3) step;
        chk("rst_readdata", rd_a, 0);
        chk("rst_rdreq", in_rdreq_a, 0);
        chk("rst_wrreq", out_wrreq_a, 0);
        chk("rst_out_data", out_data_a, 0);
        chk("rst_gain", gain_a, 0);
        chk("rst_valid", valid_a, 0);
        reset = 1'b1;
        step;
        foreach (vt[i]) begin
            if (vt[i].wr) wr(vt[i].addr, vt[i].wd);
            rd(vt[i].addr);
            chk($sformatf("reg_vec%0d", i), rd_a, vt[i].exp);
        end
        chk("bypass_applied", bypass_a, 1'b1);
        chk("gain_applied_idle", gain_a, 32'h0000_00AA);
        chk("boost_applied_idle", boost_a, 32'h1234_5678);
        avl_address = 5'h01; avl_read = 1'b1; avl_write = 1'b1; avl_writedata = 32'h55;
        step;
        avl_read = 1'b0; avl_write = 1'b0;
        chk("read_before_write", rd_a, 32'h0000_00AA);
        rd(5'h01);
        chk("read_after_write", rd_a, 32'h0000_0055);
        wr(5'h04, 0);
        // normal sample
        r0 = rd_cnt_a;
        push_in(32'h0000_1234, 1'b1);
        wr(5'h04, 1);
        wait_rd("normal_rdreq");
        wait_wr("normal_wrreq");
        step;
        chk("normal_one_rdreq", rd_cnt_a - r0, 1);
        rd(5'h03);
        chk("normal_status_idle", rd_a, 0);
        // underflow on the next tick with an empty input FIFO
        repeat (12) step;
        rd(5'h03);
        chk("underflow_set", rd_a, 32'h8);
        // overflow: output FIFO full at STORE
        out_wrfull_a = 1'b1;
        w0 = wr_cnt_a;
        push_in(32'h0000_1111, 1'b0);
        wait_rd("overflow_rdreq");
        repeat (8) step;
        wr(5'h04, 0);
        rd(5'h03);
        chk("overflow_set", rd_a, 32'h18);
        chk("overflow_no_wrreq", wr_cnt_a - w0, 0);
        out_wrfull_a = 1'b0;
        wr(5'h03, 32'h18);
        rd(5'h03);
        chk("status_w1c", rd_a, 0);
        // shadow gain held during a sample
        push_in(32'h0000_2222, 1'b1);
        wr(5'h04, 1);
        wait_rd("shadow_rdreq");
        step; step;
        wr(5'h01, 32'hAA);
        chk("shadow_hold_proc", gain_a, 32'h55);
        rd(5'h03);
        chk("busy_in_proc", rd_a[0], 1'b1);
        wait_wr("shadow_wrreq");
        step;
        chk("shadow_hold_store", gain_a, 32'h55);
        step;
        chk("shadow_applied", gain_a, 32'hAA);
        wr(5'h04, 0);
        // processed-sample counter
        wr(5'h07, 0);
        w0 = wr_cnt_a;
        for (int i = 0; i < 3; i++) push_in(32'h3000 + i, 1'b1);
        wr(5'h04, 1);
        for (int i = 0; i < 120 && wr_cnt_a - w0 < 3; i++) step;
        chk("count_three_written", wr_cnt_a - w0, 3);
        wr(5'h04, 0);
        rd(5'h07);
`ifdef SAMPLE_COUNT_EN
        chk("sample_count_3", rd_a, 3);
`else
        chk("sample_count_absent", rd_a, 0);
`endif
        wr(5'h07, 0);
        rd(5'h07);
        chk("sample_count_cleared", rd_a, 0);
        // reset in the middle of PROC
        wr(5'h03, 32'h1C);
        push_in(32'h0000_4444, 1'b1);
        wr(5'h04, 1);
        wait_rd("rstproc_rdreq");
        step; step; step;
        reset = 1'b0;
        step;
        chk("rstproc_wrreq", out_wrreq_a, 0);
        chk("rstproc_valid", valid_a, 0);
        chk("rstproc_input", input_a, 0);
        chk("rstproc_gain", gain_a, 0);
        chk("rstproc_readdata", rd_a, 0);
        reset = 1'b1;
        exp_q.delete();
        w0 = wr_cnt_a;
        repeat (10) step;
        chk("rstproc_no_wrreq", wr_cnt_a - w0, 0);
        rd(5'h03);
        chk("rstproc_status", rd_a, 0);
        rd(5'h04);
        chk("rstproc_ctrl", rd_a, 0);
        // overrun on the TICK_DIV=4 instance
        b_sel = 1'b1;
        wr(5'h04, 1);
        repeat (40) step;
        wr(5'h04, 0);
        repeat (16) step;
        rd(5'h03);
        chk("overrun_set", rd_b[2], 1'b1);
        chk("overrun_passes", rd_cnt_b >= 3, 1'b1);
        chk("overrun_one_out_per_pass", wr_cnt_b, rd_cnt_b);
        b_sel = 1'b0;
        chk("a_scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
